// File: rtl/cpu_pkg.sv
// Shared constants for the multicycle CPU: operand sizing, mult/div FSM states
// and the control-unit opcode/funct codes.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ITER   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FINISH = 2'd3
    } md_state_t;

    localparam logic [5:0] OP_RTYPE   = 6'h00;
    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;

endpackage

// File: rtl/mult_div_unit_div_core.sv
// Restoring divider on operand magnitudes, one quotient bit per step, with
// truncating-division sign correction applied to the outputs.
module div_core #(
    parameter int DATA_W = cpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dvsr;
    logic              neg_q;
    logic              neg_r;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   trial;
    logic              fits;

    // 0x80000000 maps to itself, which is the correct unsigned magnitude.
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? (~v + 1'b1) : v;
    endfunction

    always_comb begin
        shifted = {rem, quo[DATA_W-1]};
        trial   = shifted - {1'b0, dvsr};
        fits    = (shifted >= {1'b0, dvsr});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem   <= '0;
            quo   <= '0;
            dvsr  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (load) begin
            rem   <= '0;
            quo   <= mag(a);
            dvsr  <= mag(b);
            neg_q <= a[DATA_W-1] ^ b[DATA_W-1];
            neg_r <= a[DATA_W-1];
        end else if (step) begin
            rem <= fits ? trial[DATA_W-1:0] : shifted[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], fits};
        end
    end

    always_comb begin
        quotient  = neg_q ? (~quo + 1'b1) : quo;
        remainder = neg_r ? (~rem + 1'b1) : rem;
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth, inline) / divide (div_core) unit
// producing HI/LO for MFHI/MFLO with done and divide-by-zero pulses.
module mult_div_unit #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ITER   = cpu_pkg::ITER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              initMult,
    input  logic              initDiv,
    input  logic [DATA_W-1:0] Ain,
    input  logic [DATA_W-1:0] Bin,
    output logic [DATA_W-1:0] HI,
    output logic [DATA_W-1:0] LO,
    output logic              busy,
    output logic              done,
    output logic              divZero
);

    import cpu_pkg::*;

    localparam int CNT_W = $clog2(ITER);

    md_state_t         state, state_nx;
    logic [CNT_W-1:0]  count;
    logic              is_div;
    logic              start_mult;
    logic              start_div;
    logic              div_zero_req;
    logic              last_step;

    // Accumulator carries one guard bit so subtracting a -2^31 multiplicand
    // cannot overflow; the 64-bit product is still {acc[31:0], mplier}.
    logic [DATA_W:0]   acc;
    logic [DATA_W:0]   acc_sum;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] mcand;
    logic              q_m1;

    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;

    assign last_step = (count == CNT_W'(ITER - 1));
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        start_mult   = 1'b0;
        start_div    = 1'b0;
        div_zero_req = 1'b0;
        case (state)
            IDLE: begin
                if (initMult) begin
                    start_mult = 1'b1;
                    state_nx   = MULT;
                end else if (initDiv) begin
                    if (Bin != '0) begin
                        start_div = 1'b1;
                        state_nx  = DIV;
                    end else begin
                        div_zero_req = 1'b1;
                    end
                end
            end
            MULT, DIV: if (last_step) state_nx = FINISH;
            FINISH:    state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_comb begin
        case ({mplier[0], q_m1})
            2'b01:   acc_sum = acc + {mcand[DATA_W-1], mcand};
            2'b10:   acc_sum = acc - {mcand[DATA_W-1], mcand};
            default: acc_sum = acc;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            is_div  <= 1'b0;
            acc     <= '0;
            mplier  <= '0;
            mcand   <= '0;
            q_m1    <= 1'b0;
            HI      <= '0;
            LO      <= '0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            done    <= 1'b0;
            divZero <= div_zero_req;
            if (start_mult || start_div) begin
                count  <= '0;
                is_div <= start_div;
            end else if (state == MULT || state == DIV) begin
                count <= count + 1'b1;
            end
            if (start_mult) begin
                acc    <= '0;
                mplier <= Bin;
                mcand  <= Ain;
                q_m1   <= 1'b0;
            end else if (state == MULT) begin
                {acc, mplier, q_m1} <= {acc_sum[DATA_W], acc_sum, mplier};
            end
            if (state == FINISH) begin
                done <= 1'b1;
                HI   <= is_div ? div_rem : acc[DATA_W-1:0];
                LO   <= is_div ? div_quo : mplier;
            end
        end
    end

    div_core #(.DATA_W(DATA_W)) u_div_core (
        .clk       (clk),
        .reset     (reset),
        .load      (start_div),
        .step      (state == DIV),
        .a         (Ain),
        .b         (Bin),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

endmodule
